// File: rtl/pipe_stall_unit.sv
// Pipeline stall/flush controller. It merges per-stage busy requests into stall, bubble and flush
// vectors, and adds a post-reset hold window, deferred flush, a stall watchdog and a stall counter.
module pipe_stall_unit #(
    parameter int                 N_STAGES  = 5,
    parameter int                 N_SRC     = 4,
    parameter logic [3*N_SRC-1:0] SRC_STAGE = {3'd3, 3'd0, 3'd3, 3'd1},
    parameter int                 RST_HOLD  = 4,
    parameter int                 WD_LIMIT  = 1023,
    parameter int                 CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_busy,
    input  logic [N_SRC-1:0]    req,
    input  logic                flush_req,
    input  logic [2:0]          flush_stage,
    input  logic                wd_clr,
    input  logic                cnt_clr,
    output logic [N_STAGES-1:0] stall,
    output logic [N_STAGES-1:0] bubble,
    output logic [N_STAGES-1:0] flush,
    output logic                hold,
    output logic                hold_q,
    output logic                wd_timeout,
    output logic                wd_err,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int SU_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [SU_W-1:0] su_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            pend_vld;
    logic [2:0]      pend_stage;

    logic            g_hold;
    logic            any_req;
    logic [2:0]      m_stage;
    logic [2:0]      fs_sat;
    logic [2:0]      flush_eff;
    logic            wd_trip;

    // Oldest stage with an active request; every younger stage must hold behind it.
    always_comb begin
        any_req = 1'b0;
        m_stage = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i]) begin
                any_req = 1'b1;
                if (SRC_STAGE[3*i +: 3] > m_stage) m_stage = SRC_STAGE[3*i +: 3];
            end
        end
    end

    assign g_hold = ~rst | init_busy | (su_cnt != '0);
    assign hold   = g_hold | any_req;

    always_comb begin
        stall  = '0;
        bubble = '0;
        if (g_hold) begin
            stall = '1;
        end else if (any_req) begin
            for (int s = 0; s < N_STAGES; s++) begin
                stall[s]  = (s <= 32'(m_stage));
                bubble[s] = (s == 32'(m_stage) + 32'd1);
            end
        end
    end

    // A fresh request and a pending one merge to the deeper of the two.
    always_comb begin
        fs_sat    = (32'(flush_stage) > N_STAGES) ? 3'(N_STAGES) : flush_stage;
        flush_eff = pend_vld ? pend_stage : 3'd0;
        if (flush_req && (fs_sat > flush_eff)) flush_eff = fs_sat;
        flush = '0;
        if (!hold) begin
            for (int s = 0; s < N_STAGES; s++) begin
                flush[s] = (s < 32'(flush_eff));
            end
        end
    end

    assign wd_trip = hold & ~g_hold & (wd_cnt == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            su_cnt       <= SU_W'(RST_HOLD);
            hold_q       <= 1'b1;
            wd_cnt       <= '0;
            wd_timeout   <= 1'b0;
            wd_err       <= 1'b0;
            stall_cycles <= '0;
            pend_vld     <= 1'b0;
            pend_stage   <= 3'd0;
        end else begin
            if (su_cnt != '0) su_cnt <= su_cnt - SU_W'(1);
            hold_q <= hold;

            wd_timeout <= 1'b0;
            if (wd_trip) begin
                wd_cnt     <= WD_W'(WD_LIMIT);
                wd_err     <= 1'b1;
                wd_timeout <= 1'b1;
            end else if (wd_clr) begin
                wd_cnt <= '0;
                wd_err <= 1'b0;
            end else if (!hold) begin
                wd_cnt <= '0;
            end else if (!g_hold && (wd_cnt != WD_W'(WD_LIMIT))) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            if (cnt_clr)     stall_cycles <= '0;
            else if (hold_q) stall_cycles <= stall_cycles + CNT_W'(1);

            if (!hold) begin
                pend_vld   <= 1'b0;
                pend_stage <= 3'd0;
            end else if (flush_req) begin
                pend_vld   <= 1'b1;
                pend_stage <= flush_eff;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_unit.sv
// Bench for pipe_stall_unit: a cycle model pushes expected outputs to a queue at drive time,
// and they are popped and compared against the DUT before the next rising edge.
module tb_pipe_stall_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_busy = 1'b0;
    logic [3:0] req = 4'b0;
    logic       flush_req = 1'b0;
    logic [2:0] flush_stage = 3'd0;
    logic       wd_clr = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [4:0] stall, bubble, flush;
    logic       hold, hold_q, wd_timeout, wd_err;
    logic [3:0] stall_cycles;

    pipe_stall_unit #(
        .N_STAGES(5), .N_SRC(4), .SRC_STAGE({3'd3, 3'd0, 3'd3, 3'd1}),
        .RST_HOLD(4), .WD_LIMIT(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy), .req(req),
        .flush_req(flush_req), .flush_stage(flush_stage), .wd_clr(wd_clr),
        .cnt_clr(cnt_clr), .stall(stall), .bubble(bubble), .flush(flush),
        .hold(hold), .hold_q(hold_q), .wd_timeout(wd_timeout), .wd_err(wd_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] stall, bubble, flush;
        logic       hold, hold_q, to, err;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int   src_stage[4] = '{1, 3, 0, 3};
    int   m_su, m_wd, m_ps;
    bit   m_hq, m_to, m_err, m_pv;
    logic [3:0] m_cnt;
    bit   m_g, m_hold;
    int   m_eff;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_su = 4; m_wd = 0; m_ps = 0;
        m_hq = 1; m_to = 0; m_err = 0; m_pv = 0;
        m_cnt = 4'd0;
    endtask

    task automatic calc(output exp_t e);
        int  m, fs;
        bit  any;
        if (!rst) model_reset();
        m_g = !rst || init_busy || (m_su != 0);
        any = 0; m = 0;
        for (int i = 0; i < 4; i++)
            if (req[i]) begin
                any = 1;
                if (src_stage[i] > m) m = src_stage[i];
            end
        m_hold = m_g || any;
        fs = (flush_stage > 5) ? 5 : int'(flush_stage);
        m_eff = m_pv ? m_ps : 0;
        if (flush_req && fs > m_eff) m_eff = fs;
        e.stall  = m_g ? 5'h1f : (any ? 5'((1 << (m + 1)) - 1) : 5'h00);
        e.bubble = (!m_g && any && m < 4) ? 5'(1 << (m + 1)) : 5'h00;
        e.flush  = m_hold ? 5'h00 : 5'((1 << m_eff) - 1);
        e.hold   = m_hold;
        e.hold_q = m_hq;
        e.to     = m_to;
        e.err    = m_err;
        e.cnt    = m_cnt;
    endtask

    task automatic model_edge();
        bit trip;
        if (!rst) begin
            model_reset();
            return;
        end
        if (cnt_clr) m_cnt = 4'd0;
        else if (m_hq) m_cnt = m_cnt + 4'd1;
        m_hq = m_hold;
        trip = m_hold && !m_g && (m_wd == 7);
        m_to = 0;
        if (trip) begin m_wd = 8; m_err = 1; m_to = 1; end
        else if (wd_clr) begin m_wd = 0; m_err = 0; end
        else if (!m_hold) m_wd = 0;
        else if (!m_g && m_wd < 8) m_wd++;
        if (!m_hold) begin m_pv = 0; m_ps = 0; end
        else if (flush_req) begin m_pv = 1; m_ps = m_eff; end
        if (m_su != 0) m_su--;
    endtask

    // Called at the falling edge with inputs already driven; returns at the next falling edge.
    task automatic cyc();
        exp_t e, g;
        #1;
        calc(e);
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check_val("stall",  32'(stall),        32'(g.stall));
        check_val("bubble", 32'(bubble),       32'(g.bubble));
        check_val("flush",  32'(flush),        32'(g.flush));
        check_val("hold",   32'(hold),         32'(g.hold));
        check_val("hold_q", 32'(hold_q),       32'(g.hold_q));
        check_val("wd_to",  32'(wd_timeout),   32'(g.to));
        check_val("wd_err", 32'(wd_err),       32'(g.err));
        check_val("cnt",    32'(stall_cycles), 32'(g.cnt));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_pulses();
        flush_req = 0; wd_clr = 0; cnt_clr = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // reset and post-reset hold window
        for (int k = 0; k < 3; k++) begin
            #1 check_val("rst_stall", 32'(stall), 32'h1f);
            check_val("rst_hold", 32'(hold), 32'd1);
            cyc();
        end
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            #1 check_val("su_hold", 32'(hold), 32'd1);
            cyc();
        end
        #1 check_val("su_done_hold", 32'(hold), 32'd0);
        check_val("su_done_stall", 32'(stall), 32'h00);
        cyc();
        cyc();
        check_val("su_cnt", 32'(stall_cycles), 32'd5);

        // stall/bubble vectors
        req = 4'b0001;
        #1 check_val("t2_stall_a", 32'(stall), 32'h03);
        check_val("t2_bub_a", 32'(bubble), 32'h04);
        cyc();
        req = 4'b0011;
        #1 check_val("t2_stall_b", 32'(stall), 32'h0f);
        check_val("t2_bub_b", 32'(bubble), 32'h10);
        cyc();
        req = 4'b0100;
        cyc();
        init_busy = 1; req = 4'b0001;
        #1 check_val("init_stall", 32'(stall), 32'h1f);
        check_val("init_bub", 32'(bubble), 32'h00);
        cyc();
        init_busy = 0; req = 4'b0000;
        cyc();

        // deferred flush behind a held stage
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            flush_req = (k == 1); flush_stage = 3'd3;
            #1 check_val("t3_nofl", 32'(flush), 32'h00);
            cyc();
        end
        clear_pulses();
        req = 4'b0000;
        #1 check_val("t3_fl", 32'(flush), 32'h07);
        cyc();
        check_val("t3_fl_once", 32'(flush), 32'h00);
        cyc();

        // two requests while held merge by max
        req = 4'b0001;
        flush_req = 1; flush_stage = 3'd2; cyc();
        flush_stage = 3'd4; cyc();
        clear_pulses(); cyc();
        req = 4'b0000;
        #1 check_val("t4_fl", 32'(flush), 32'h0f);
        cyc();
        check_val("t4_fl_once", 32'(flush), 32'h00);

        // immediate flush, saturation and no-op
        flush_req = 1; flush_stage = 3'd7;
        #1 check_val("fl_sat", 32'(flush), 32'h1f);
        cyc();
        flush_stage = 3'd0;
        #1 check_val("fl_zero", 32'(flush), 32'h00);
        cyc();
        clear_pulses(); cyc();

        // watchdog
        wd_clr = 1; cyc(); clear_pulses();
        for (int k = 1; k <= 20; k++) begin
            req = 4'b0010;
            cyc();
            check_val("t5_to", 32'(wd_timeout), (k == 8) ? 32'd1 : 32'd0);
        end
        req = 4'b0000;
        cyc(); cyc();
        check_val("t5_err_sticky", 32'(wd_err), 32'd1);
        wd_clr = 1; cyc(); clear_pulses();
        check_val("t5_err_clr", 32'(wd_err), 32'd0);

        // perf counter wrap and clear-wins
        cnt_clr = 1; cyc(); clear_pulses();
        for (int k = 0; k < 17; k++) begin
            req = 4'b0100;
            cyc();
        end
        req = 4'b0000; cyc();
        check_val("t6_wrap", 32'(stall_cycles), 32'd1);
        req = 4'b0100; cyc();
        cnt_clr = 1; cyc(); clear_pulses();
        check_val("t6_clr", 32'(stall_cycles), 32'd0);
        wd_clr = 1; cyc(); clear_pulses();

        // asynchronous reset mid-operation
        req = 4'b0010; cyc(); cyc(); cyc();
        rst = 0;
        #1 check_val("arst_cnt", 32'(stall_cycles), 32'd0);
        check_val("arst_hq", 32'(hold_q), 32'd1);
        cyc();
        rst = 1; req = 4'b0000;
        for (int k = 0; k < 6; k++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
